// File: rtl/seq_multiplier.sv
// seq_multiplier: sequential shift-add unsigned multiplier.
// Produces a 2*WIDTH-bit product over WIDTH clock cycles. Each iteration
// adds the multiplicand into the high half via a carry-lookahead adder and
// shifts {carry, acc, q} right by one. Operands and result move over
// valid/ready handshakes.
//
// Build option: define SEQ_MULTIPLIER_ZERO_BYPASS_EN to short-circuit
// zero operands. The FSM then goes straight to DONE with Product = 0.
// Without it, every operation takes WIDTH iterations.

module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
  output logic [2*WIDTH-1:0]   Product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  // Adder width padded up to a whole number of 4-bit lookahead groups.
  localparam int NGRP  = (WIDTH + 3) / 4;
  localparam int PW    = NGRP * 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [WIDTH-1:0]     m;
  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     acc;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   product_q;

  logic                 last_iter;
  logic                 zero_op;
  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum;
  logic                 carry;

  // Carry-lookahead adder (carry-in 0).
  // Each 4-bit group resolves its carries directly from generate/propagate.
  // Groups chain through their group carry-out.
  // Returns {carry_out, sum}, so the carry is never dropped.
  function automatic logic [WIDTH:0] cla_add(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    logic [PW-1:0] g;
    logic [PW-1:0] p;
    logic [PW:0]   c;
    g = PW'(x) & PW'(y);
    p = PW'(x) ^ PW'(y);
    c = '0;
    for (int grp = 0; grp < NGRP; grp++) begin
      c[4*grp+1] = g[4*grp]
                 | (p[4*grp] & c[4*grp]);
      c[4*grp+2] = g[4*grp+1]
                 | (p[4*grp+1] & g[4*grp])
                 | (p[4*grp+1] & p[4*grp] & c[4*grp]);
      c[4*grp+3] = g[4*grp+2]
                 | (p[4*grp+2] & g[4*grp+1])
                 | (p[4*grp+2] & p[4*grp+1] & g[4*grp])
                 | (p[4*grp+2] & p[4*grp+1] & p[4*grp] & c[4*grp]);
      c[4*grp+4] = g[4*grp+3]
                 | (p[4*grp+3] & g[4*grp+2])
                 | (p[4*grp+3] & p[4*grp+2] & g[4*grp+1])
                 | (p[4*grp+3] & p[4*grp+2] & p[4*grp+1] & g[4*grp])
                 | (p[4*grp+3] & p[4*grp+2] & p[4*grp+1] & p[4*grp] & c[4*grp]);
    end
    return {c[WIDTH], p[WIDTH-1:0] ^ c[WIDTH-1:0]};
  endfunction

  // Iteration signals.
  // The multiplicand is added only when the current multiplier LSB is set.
  assign addend       = q[0] ? m : '0;
  assign {carry, sum} = cla_add(acc, addend);
  assign last_iter    = (cnt == CNT_W'(WIDTH - 1));

`ifdef SEQ_MULTIPLIER_ZERO_BYPASS_EN
  assign zero_op = (A == '0) || (B == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Handshake outputs decode from state only.
  // No combinational path exists from In_Valid/Out_Ready.
  assign In_Ready  = (state == IDLE);
  assign Out_Valid = (state == DONE);
  assign Product   = product_q;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  // Out_Ready retires DONE without also accepting, so new operands wait
  // one more edge in IDLE.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE: if (In_Valid)  state_nxt = zero_op ? DONE : RUN;
      RUN:  if (last_iter) state_nxt = DONE;
      DONE: if (Out_Ready) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, shift-add during RUN, capture the result on
  // the last iteration. Product is written only when entering DONE.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      // NOTE: these are plain flops, not a RAM, so they can take the async
      // clear. Clearing them guarantees an aborted multiply leaves no
      // partial result behind.
      m         <= '0;
      q         <= '0;
      acc       <= '0;
      cnt       <= '0;
      product_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (In_Valid) begin
            m   <= A;
            q   <= B;
            acc <= '0;
            cnt <= '0;
            if (zero_op) product_q <= '0;
          end
        end
        RUN: begin
          acc <= {carry, sum[WIDTH-1:1]};
          q   <= {sum[0], q[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (last_iter) product_q <= {carry, sum, q[WIDTH-1:1]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (WIDTH = 16).
// Expected products come from plain integer multiplication. Expected latency
// comes from the handshake rules: WIDTH edges after accept, or the accept
// edge itself for zero operands when SEQ_MULTIPLIER_ZERO_BYPASS_EN is defined.

module tb_seq_multiplier;

  localparam int W = 16;

  logic           Clk = 1'b0;
  logic           Reset_n;
  logic           In_Valid;
  logic           In_Ready;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           Out_Valid;
  logic           Out_Ready;
  logic [2*W-1:0] Product;

  int errors = 0;
  int checks = 0;

  seq_multiplier #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .A         (A),
    .B         (B),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Product   (Product)
  );

  always #5 Clk = ~Clk;

  // Reference model: the unsigned product at full width.
  function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
    logic [2*W-1:0] r;
    r = {{W{1'b0}}, a};
    r = r * {{W{1'b0}}, b};
    return r;
  endfunction

  // Edges after the accept edge until Out_Valid is seen. The bypass case
  // lands in DONE on the accept edge itself, so Out_Valid is already high in
  // the cycle right after accept.
  function automatic int ref_latency(input logic [W-1:0] a,
                                     input logic [W-1:0] b);
`ifdef SEQ_MULTIPLIER_ZERO_BYPASS_EN
    if (a == '0 || b == '0) return 0;
`endif
    return W;
  endfunction

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Wait (bounded) for In_Ready, then present one operand pair for one edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input string name);
    int n = 0;
    while (In_Ready !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    checks++;
    if (In_Ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept_timeout: In_Ready=%b required 1", name, In_Ready);
    end
    A = a;
    B = b;
    In_Valid = 1'b1;
    tick();
    In_Valid = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
  endtask

  // Wait (bounded) for the result and check latency, value and In_Ready.
  task automatic expect_result(input logic [W-1:0] a, input logic [W-1:0] b,
                               input string name);
    int lat = 0;
    while (Out_Valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != ref_latency(a, b)) begin
      errors++;
      $display("FAIL %s latency: got %0d edges required %0d", name, lat, ref_latency(a, b));
    end
    checks++;
    if (Product !== ref_product(a, b)) begin
      errors++;
      $display("FAIL %s product: got %h required %h (a=%h b=%h)",
               name, Product, ref_product(a, b), a, b);
    end
    checks++;
    if (In_Ready !== 1'b0) begin
      errors++;
      $display("FAIL %s in_ready_in_done: got %b required 0", name, In_Ready);
    end
  endtask

  // Complete the output handshake and check that the block returns to IDLE.
  task automatic retire(input string name);
    Out_Ready = 1'b1;
    tick();
    Out_Ready = 1'b0;
    checks++;
    if (Out_Valid !== 1'b0 || In_Ready !== 1'b1) begin
      errors++;
      $display("FAIL %s retire: Out_Valid=%b In_Ready=%b required 0/1",
               name, Out_Valid, In_Ready);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (In_Ready !== 1'b1 || Out_Valid !== 1'b0 || Product !== '0) begin
      errors++;
      $display("FAIL reset_state: In_Ready=%b Out_Valid=%b Product=%h required 1/0/0",
               In_Ready, Out_Valid, Product);
    end
  endtask

  task automatic test_directed();
    send(16'd3, 16'd5, "mul_3x5");
    expect_result(16'd3, 16'd5, "mul_3x5");
    checks++;
    if (Product !== 32'h0000000F) begin
      errors++;
      $display("FAIL mul_3x5 const: got %h required 0000000f", Product);
    end
    retire("mul_3x5");
    send(16'hFFFF, 16'hFFFF, "mul_max");
    expect_result(16'hFFFF, 16'hFFFF, "mul_max");
    checks++;
    if (Product !== 32'hFFFE0001) begin
      errors++;
      $display("FAIL mul_max const: got %h required fffe0001", Product);
    end
    retire("mul_max");
  endtask

  // Hold Out_Ready low for 10 cycles while pulsing In_Valid with other operands.
  task automatic test_backpressure();
    send(16'h8000, 16'h0002, "backpressure");
    expect_result(16'h8000, 16'h0002, "backpressure");
    for (int i = 0; i < 10; i++) begin
      A = W'($urandom);
      B = W'($urandom);
      In_Valid = i[0];
      tick();
      checks++;
      if (Product !== 32'h00010000 || Out_Valid !== 1'b1 || In_Ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure hold[%0d]: Product=%h Out_Valid=%b In_Ready=%b required 00010000/1/0",
                 i, Product, Out_Valid, In_Ready);
      end
    end
    In_Valid = 1'b0;
    retire("backpressure");
  endtask

  // Asynchronous reset in the middle of RUN, then a fresh multiply.
  task automatic test_reset_mid_run();
    send(16'h1234, 16'h5678, "reset_mid_run");
    repeat (5) tick();
    #2;
    Reset_n = 1'b0;
    #1;
    checks++;
    if (Out_Valid !== 1'b0 || In_Ready !== 1'b1 || Product !== '0) begin
      errors++;
      $display("FAIL reset_mid_run async: Out_Valid=%b In_Ready=%b Product=%h required 0/1/0",
               Out_Valid, In_Ready, Product);
    end
    #2;
    Reset_n = 1'b1;
    tick();
    send(16'd7, 16'd9, "after_reset");
    expect_result(16'd7, 16'd9, "after_reset");
    checks++;
    if (Product !== 32'd63) begin
      errors++;
      $display("FAIL after_reset const: got %h required 0000003f", Product);
    end
    retire("after_reset");
  endtask

  // Out_Ready and In_Valid together in DONE: retire now, accept one edge later.
  task automatic test_back_to_back();
    logic [W-1:0] a;
    logic [W-1:0] b;
    a = W'($urandom_range(1, 16'hFFFF));
    b = W'($urandom_range(1, 16'hFFFF));
    send(a, b, "b2b_first");
    expect_result(a, b, "b2b_first");
    A = 16'd2;
    B = 16'd2;
    In_Valid  = 1'b1;
    Out_Ready = 1'b1;
    tick();
    Out_Ready = 1'b0;
    checks++;
    if (Out_Valid !== 1'b0 || In_Ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b no_accept_in_done: Out_Valid=%b In_Ready=%b required 0/1",
               Out_Valid, In_Ready);
    end
    tick();
    In_Valid = 1'b0;
    checks++;
    if (In_Ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b accept_next_edge: In_Ready=%b required 0", In_Ready);
    end
    expect_result(16'd2, 16'd2, "b2b_second");
    retire("b2b_second");
  endtask

  task automatic test_zero();
    send(16'd0, 16'h1234, "zero_a");
    expect_result(16'd0, 16'h1234, "zero_a");
    retire("zero_a");
    send(16'hBEEF, 16'd0, "zero_b");
    expect_result(16'hBEEF, 16'd0, "zero_b");
    retire("zero_b");
  endtask

  // Random operands (some forced to 0 or all-ones) with random backpressure.
  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    int sel;
    int dly;
    for (int i = 0; i < 16; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      sel = $urandom_range(0, 7);
      if (sel == 0) a = '0;
      if (sel == 1) b = '0;
      if (sel == 2) a = '1;
      if (sel == 3) b = '1;
      send(a, b, "random");
      expect_result(a, b, "random");
      dly = $urandom_range(0, 3);
      for (int k = 0; k < dly; k++) begin
        tick();
        checks++;
        if (Product !== ref_product(a, b) || Out_Valid !== 1'b1) begin
          errors++;
          $display("FAIL random hold: Product=%h Out_Valid=%b required %h/1",
                   Product, Out_Valid, ref_product(a, b));
        end
      end
      retire("random");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n   = 1'b0;
    In_Valid  = 1'b0;
    Out_Ready = 1'b0;
    A         = '0;
    B         = '0;
    repeat (2) @(posedge Clk);
    #1;
    test_reset();
    Reset_n = 1'b1;
    tick();
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_zero();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
